wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that owns the register file's single write port (`wr`, `addr3`, `data3`). It merges two result sources:
- the in-order pipeline write-back, which has priority and is never stalled;
- a multi-cycle unit (mul/div) result stream, buffered in a small FIFO behind a ready handshake.

It drops writes to `$zero` and exposes bypass lookups so the decode stage can see values that are queued but not yet written.

## Interface
Parameters:
- `DEPTH`, 2: multi-cycle result FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `p_valid`  in  1  pipeline write-back request this cycle.
- `p_addr`  in  5  pipeline destination register.
- `p_data`  in  32  pipeline result.
- `m_valid`  in  1  multi-cycle result offered.
- `m_addr`  in  5  multi-cycle destination register.
- `m_data`  in  32  multi-cycle result.
- `m_ready`  out  1  FIFO can accept; transfer on `m_valid && m_ready` at posedge.
- `wr`  out  1  register file write enable (registered).
- `addr3`  out  5  register file write address (registered).
- `data3`  out  32  register file write data (registered).
- `q_addr1`  in  5  decode read address 1 for bypass lookup.
- `q_addr2`  in  5  decode read address 2 for bypass lookup.
- `byp1_hit`  out  1  pending write to `q_addr1` exists.
- `byp1_data`  out  32  value of that pending write.
- `byp2_hit`  out  1  same as `byp1_hit`, for `q_addr2`.
- `byp2_data`  out  32  same as `byp1_data`, for `q_addr2`.
- `pending`  out  1  FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Per posedge, exactly one candidate is selected:
  - if `p_valid`, the pipeline request wins;
  - else if the FIFO is non-empty, the head is popped;
  - else idle.
- Output stage loads the candidate: `wr` = 1 only if a candidate exists and its address ≠ 0; `addr3`/`data3` load the candidate fields.
- An address-0 candidate is consumed (popped if from the FIFO) but `wr` = 0. When `wr` = 0, `addr3`/`data3` hold their previous values.
- FIFO:
  - circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - `count` tracks occupancy, 0..DEPTH;
  - `m_ready` = (`count` < `DEPTH`), derived from registered state only;
  - when full, a push is refused even if a pop occurs that cycle;
  - push and pop in the same cycle leave `count` unchanged;
  - there is no fall-through: an entry pushed at edge N is poppable at edge N+1 at the earliest.
- Address-0 results are accepted into the FIFO normally; they are dropped on pop.
- Bypass (combinational) for each query address q:
  - candidate sources are valid FIFO entries plus the output stage when `wr` = 1;
  - priority is output stage first, then FIFO entries youngest to oldest;
  - q = 0 never hits; on a miss, data = 0.
- Usage contract: the pipeline must not issue a `p_valid` write to a register that has a pending FIFO entry; decode stalls on `byp*_hit` from the FIFO. If the contract is violated, write order is arrival order at the output stage, and the stated bypass priority still holds.
- Reset (asynchronous, any time):
  - `wr` = 0, `addr3` = 0, `data3` = 0;
  - FIFO emptied: `count` = 0, `pending` = 0, `m_ready` = 1;
  - bypass hits = 0;
  - queued results are discarded and no partial write is emitted.

## Timing
- Pipeline path: `p_valid` sampled at edge N, so `wr`/`addr3`/`data3` are valid during cycle N+1. The register file commits at the negedge inside cycle N+1 and reads reflect the value from that negedge onward.
- Multi-cycle path, minimum latency: push at edge N, pop at N+1, `wr` high in cycle N+2.
- Starvation: continuous `p_valid` starves the FIFO. `m_ready` falls once `count` = `DEPTH`, and the FIFO drains on the first cycle with `p_valid` = 0.
- Bypass outputs are combinational from `q_addr*` and registered state; they add no cycle.

## Configuration
- `WB_BYPASS_EN` defined: bypass comparators and muxes are built as described above.
- `WB_BYPASS_EN` undefined:
  - `byp1_hit`/`byp2_hit` are tied 0 and `byp1_data`/`byp2_data` are tied 0;
  - no comparator logic is generated;
  - decode then stalls on `pending`.
- All other behaviour is identical in both builds.

## Test plan
- Reset mid-traffic: `DEPTH`=2, queue holds 2 entries, assert `rst` between edges. Outputs clear immediately: `count`=0, `wr`=0, `m_ready`=1. No write follows reset release.
- Pipeline write: `p_valid`=1, `p_addr`=8, `p_data`=32'hDEADBEEF at edge N. During cycle N+1, `wr`=1, `addr3`=8, `data3`=32'hDEADBEEF. The next cycle with `p_valid`=0 gives `wr`=0.
- Zero drop: `p_addr`=0 with `p_data`=32'h1234 gives `wr`=0. Push `m_addr`=0 and pop it: `count` decrements and `wr` stays 0.
- Priority and fill:
  - push `m_addr`=2/`m_data`=5 and `m_addr`=3/`m_data`=6 while `p_valid`=1 for 3 cycles: `count`=2 and `m_ready`=0;
  - then drop `p_valid`: writes r2=5, then r3=6 on consecutive cycles, and `count` returns to 0.
- Full with simultaneous pop: with `count`=2, `p_valid`=0 and `m_valid`=1, the push is refused, one pop occurs, and `count`=1.
- Bypass (with `WB_BYPASS_EN`): FIFO holds r9=7 (older) and r9=11 (younger), `q_addr1`=9, `q_addr2`=0. Required: `byp1_hit`=1, `byp1_data`=11, `byp2_hit`=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: the pipeline result wins, and multi-cycle results queue in a FIFO behind m_ready.
// Build with WB_BYPASS_EN defined to get bypass lookups into the output stage and FIFO; otherwise the byp* outputs are tied to 0.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_valid,
  input  logic [4:0]               p_addr,
  input  logic [31:0]              p_data,
  input  logic                     m_valid,
  input  logic [4:0]               m_addr,
  input  logic [31:0]              m_data,
  output logic                     m_ready,
  output logic                     wr,
  output logic [4:0]               addr3,
  output logic [31:0]              data3,
  input  logic [4:0]               q_addr1,
  input  logic [4:0]               q_addr2,
  output logic                     byp1_hit,
  output logic [31:0]              byp1_data,
  output logic                     byp2_hit,
  output logic [31:0]              byp2_data,
  output logic                     pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic          push;
  logic          pop;
  logic          cand_vld;
  logic [4:0]    cand_addr;
  logic [31:0]   cand_data;
  logic          cand_wr;

  // Flow control depends only on registered occupancy, so a pop in the same cycle never frees a slot.
  assign m_ready = (count < FULL);
  assign pending = (count != '0);
  assign push    = m_valid && m_ready;
  assign pop     = !p_valid && pending;

  always_comb begin
    cand_vld  = p_valid || pending;
    cand_addr = p_addr;
    cand_data = p_data;
    if (!p_valid) begin
      cand_addr = fifo_addr[rd_ptr];
      cand_data = fifo_data[rd_ptr];
    end
  end

  assign cand_wr = cand_vld && (cand_addr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= m_addr;
      fifo_data[wr_ptr] <= m_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr    <= 1'b0;
      addr3 <= 5'd0;
      data3 <= 32'd0;
    end else begin
      wr <= cand_wr;
      if (cand_wr) begin
        addr3 <= cand_addr;
        data3 <= cand_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match wins; the output stage then overrides all FIFO entries.
  function automatic logic [32:0] lookup(input logic [4:0] q);
    logic [32:0]   r;
    logic [AW-1:0] idx;
    r = '0;
    if (q != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + AW'(i);
        if ((CW'(i) < count) && (fifo_addr[idx] == q))
          r = {1'b1, fifo_data[idx]};
      end
      if (wr && (addr3 == q))
        r = {1'b1, data3};
    end
    return r;
  endfunction

  assign {byp1_hit, byp1_data} = lookup(q_addr1);
  assign {byp2_hit, byp2_data} = lookup(q_addr2);
`else
  logic unused_q;
  assign unused_q  = ^{q_addr1, q_addr2};
  assign byp1_hit  = 1'b0;
  assign byp1_data = 32'd0;
  assign byp2_hit  = 1'b0;
  assign byp2_data = 32'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_ready;
  logic        wr;
  logic [4:0]  addr3;
  logic [31:0] data3;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        byp1_hit;
  logic [31:0] byp1_data;
  logic        byp2_hit;
  logic [31:0] byp2_data;
  logic        pending;
  logic [$clog2(DEPTH):0] count;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .wr(wr), .addr3(addr3), .data3(data3),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data),
    .pending(pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the queued results in arrival order, plus the last write presented to the register file.
  logic [36:0] exp_q [$];
  logic        exp_wr;
  logic [4:0]  exp_addr3;
  logic [31:0] exp_data3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [32:0] byp_model(input logic [4:0] q);
    logic [32:0] r;
    r = '0;
    if (q != 5'd0) begin
`ifdef WB_BYPASS_EN
      if (exp_wr && exp_addr3 == q) r = {1'b1, exp_data3};
      else begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i][36:32] == q) begin
            r = {1'b1, exp_q[i][31:0]};
            break;
          end
        end
      end
`endif
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [32:0] b1;
    logic [32:0] b2;
    b1 = byp_model(q_addr1);
    b2 = byp_model(q_addr2);
    check({tag, ".wr"},      wr,      exp_wr);
    check({tag, ".addr3"},   addr3,   exp_addr3);
    check({tag, ".data3"},   data3,   exp_data3);
    check({tag, ".count"},   count,   exp_q.size());
    check({tag, ".m_ready"}, m_ready, exp_q.size() < DEPTH);
    check({tag, ".pending"}, pending, exp_q.size() != 0);
    check({tag, ".b1hit"},   byp1_hit,  b1[32]);
    check({tag, ".b1dat"},   byp1_data, b1[31:0]);
    check({tag, ".b2hit"},   byp2_hit,  b2[32]);
    check({tag, ".b2dat"},   byp2_data, b2[31:0]);
  endtask

  // Drive one cycle of requests just after a negedge, advance the model across the posedge, check at the next negedge.
  task automatic step(input string tag,
                      input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bit          do_push;
    bit          do_pop;
    bit          cv;
    logic [4:0]  ca;
    logic [31:0] cd;
    logic [36:0] head;
    p_valid = pv; p_addr = pa; p_data = pd;
    m_valid = mv; m_addr = ma; m_data = md;
    do_push = mv && (exp_q.size() < DEPTH);
    do_pop  = !pv && (exp_q.size() > 0);
    cv = 1'b0; ca = '0; cd = '0;
    if (pv) begin
      cv = 1'b1; ca = pa; cd = pd;
    end else if (do_pop) begin
      cv = 1'b1; ca = exp_q[0][36:32]; cd = exp_q[0][31:0];
    end
    @(posedge clk);
    if (cv && ca != 5'd0) begin
      exp_wr = 1'b1; exp_addr3 = ca; exp_data3 = cd;
    end else begin
      exp_wr = 1'b0;
    end
    if (do_pop)  head = exp_q.pop_front();
    if (do_push) exp_q.push_back({ma, md});
    @(negedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_wr = 1'b0; exp_addr3 = '0; exp_data3 = '0;
  endtask

  initial begin
    rst = 1'b1;
    p_valid = 0; p_addr = 0; p_data = 0;
    m_valid = 0; m_addr = 0; m_data = 0;
    q_addr1 = 0; q_addr2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Pipeline write appears in the next cycle, then idles.
    step("pwr", 1, 5'd8, 32'hDEADBEEF, 0, 0, 0);
    check("pwr.wr_c", wr, 1);
    check("pwr.addr_c", addr3, 8);
    check("pwr.data_c", data3, 32'hDEADBEEF);
    step("pidle", 0, 0, 0, 0, 0, 0);
    check("pidle.wr_c", wr, 0);

    // Address-0 results are consumed without a write, from either source.
    step("zp", 1, 5'd0, 32'h1234, 0, 0, 0);
    check("zp.wr_c", wr, 0);
    step("zpush", 0, 0, 0, 1, 5'd0, 32'h55);
    check("zpush.count_c", count, 1);
    step("zpop", 0, 0, 0, 0, 0, 0);
    check("zpop.count_c", count, 0);
    check("zpop.wr_c", wr, 0);

    // Pipeline priority starves the FIFO until it fills, then the FIFO drains in order.
    step("fill0", 1, 5'd20, 32'hA0, 1, 5'd2, 32'd5);
    step("fill1", 1, 5'd21, 32'hA1, 1, 5'd3, 32'd6);
    step("fill2", 1, 5'd22, 32'hA2, 0, 0, 0);
    check("fill.count_c", count, 2);
    check("fill.m_ready_c", m_ready, 0);
    step("drain0", 0, 0, 0, 0, 0, 0);
    check("drain0.addr_c", addr3, 2);
    check("drain0.data_c", data3, 5);
    step("drain1", 0, 0, 0, 0, 0, 0);
    check("drain1.addr_c", addr3, 3);
    check("drain1.data_c", data3, 6);
    check("drain1.count_c", count, 0);

    // A full FIFO refuses a push even while it pops.
    step("full0", 1, 5'd23, 32'hB0, 1, 5'd4, 32'd7);
    step("full1", 1, 5'd24, 32'hB1, 1, 5'd5, 32'd8);
    step("fullpop", 0, 0, 0, 1, 5'd6, 32'd9);
    check("fullpop.count_c", count, 1);
    check("fullpop.addr_c", addr3, 4);
    step("fulldrain", 0, 0, 0, 0, 0, 0);
    check("fulldrain.addr_c", addr3, 5);

    // Two queued writes to the same register: the younger must be returned.
    step("byp0", 1, 5'd12, 32'hC0, 1, 5'd9, 32'd7);
    step("byp1", 1, 5'd13, 32'hC1, 1, 5'd9, 32'd11);
    q_addr1 = 5'd9; q_addr2 = 5'd0;
    #1;
    check_all("byp");
`ifdef WB_BYPASS_EN
    check("byp.hit1_c", byp1_hit, 1);
    check("byp.dat1_c", byp1_data, 11);
`else
    check("byp.hit1_c", byp1_hit, 0);
    check("byp.dat1_c", byp1_data, 0);
`endif
    check("byp.hit2_c", byp2_hit, 0);

    // Asynchronous reset between edges with a full queue.
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("arst.count_c", count, 0);
    check("arst.wr_c", wr, 0);
    check("arst.m_ready_c", m_ready, 1);
    check_all("arst");
    @(negedge clk);
    rst = 1'b0;
    step("postrst", 0, 0, 0, 0, 0, 0);
    check("postrst.wr_c", wr, 0);

    // Random traffic over a narrow address range to provoke bypass collisions.
    for (int n = 0; n < 500; n++) begin
      q_addr1 = 5'($urandom_range(0, 7));
      q_addr2 = 5'($urandom_range(0, 7));
      step("rnd",
           ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
